bcd_time_entry: RTL and testbench

BCD_TIME_ENTRY -- requirements
Module: bcd_time_entry

---
 rtl/bcd_time_entry.sv | 168 ++++++++++++++++
 tb/tb_bcd_time_entry.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_entry.sv
// BCD digit-by-digit time entry: collects HH:MM digits, validates each, commits binary time.
// Optional macro SECONDS_ENTRY_EN extends the sequence with SS digits.
module bcd_time_entry (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       busy,
  output logic [2:0] pos,
  output logic       key_err,
  output logic       load,
  output logic [5:0] tmp_hour,
  output logic [5:0] tmp_minute,
  output logic [5:0] tmp_second
);

  typedef enum logic [2:0] {IDLE, D_H1, D_H0, D_M1, D_M0, D_S1, D_S0, COMMIT} state_t;

  state_t     state, state_next;
  logic [3:0] h1, h0, m1, m0;
`ifdef SECONDS_ENTRY_EN
  logic [3:0] s1, s0;
`endif
  logic [3:0] digit_max;
  logic       accept, reject, clear_digits, do_commit;

  // Tens digit times ten plus ones digit, widened to 7 bits before narrowing.
  function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return 6'({3'b000, tens} * 7'd10 + {3'b000, ones});
  endfunction

  always_comb begin
    digit_max = 4'd0;
    case (state)
      D_H1:    digit_max = 4'd2;
      D_H0:    digit_max = (h1 == 4'd2) ? 4'd3 : 4'd9;
      D_M1:    digit_max = 4'd5;
      D_M0:    digit_max = 4'd9;
      D_S1:    digit_max = 4'd5;
      D_S0:    digit_max = 4'd9;
      default: digit_max = 4'd0;
    endcase
  end

  // Priority in a busy state: cancel, then restart, then commit, then key handling.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    reject       = 1'b0;
    clear_digits = 1'b0;
    do_commit    = 1'b0;
    if (state == IDLE) begin
      if (start && !cancel) begin
        state_next   = D_H1;
        clear_digits = 1'b1;
      end
    end else if (cancel) begin
      state_next   = IDLE;
      clear_digits = 1'b1;
    end else if (start) begin
      state_next   = D_H1;
      clear_digits = 1'b1;
    end else if (state == COMMIT) begin
      do_commit    = 1'b1;
      state_next   = IDLE;
      clear_digits = 1'b1;
    end else if (key_valid) begin
      if (key_digit <= digit_max) begin
        accept = 1'b1;
        case (state)
          D_H1: state_next = D_H0;
          D_H0: state_next = D_M1;
          D_M1: state_next = D_M0;
`ifdef SECONDS_ENTRY_EN
          D_M0: state_next = D_S1;
          D_S1: state_next = D_S0;
          D_S0: state_next = COMMIT;
`else
          D_M0: state_next = COMMIT;
`endif
          default: state_next = IDLE;
        endcase
      end else begin
        reject = 1'b1;
      end
    end
  end

  always_comb begin
    pos = 3'd7;
    case (state)
      D_H1:    pos = 3'd0;
      D_H0:    pos = 3'd1;
      D_M1:    pos = 3'd2;
      D_M0:    pos = 3'd3;
      D_S1:    pos = 3'd4;
      D_S0:    pos = 3'd5;
      default: pos = 3'd7;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      key_err <= 1'b0;
      load    <= 1'b0;
    end else begin
      state   <= state_next;
      key_err <= reject;
      load    <= do_commit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1 <= 4'd0;
      h0 <= 4'd0;
      m1 <= 4'd0;
      m0 <= 4'd0;
`ifdef SECONDS_ENTRY_EN
      s1 <= 4'd0;
      s0 <= 4'd0;
`endif
    end else if (clear_digits) begin
      h1 <= 4'd0;
      h0 <= 4'd0;
      m1 <= 4'd0;
      m0 <= 4'd0;
`ifdef SECONDS_ENTRY_EN
      s1 <= 4'd0;
      s0 <= 4'd0;
`endif
    end else if (accept) begin
      case (state)
        D_H1: h1 <= key_digit;
        D_H0: h0 <= key_digit;
        D_M1: m1 <= key_digit;
        D_M0: m0 <= key_digit;
`ifdef SECONDS_ENTRY_EN
        D_S1: s1 <= key_digit;
        D_S0: s0 <= key_digit;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmp_hour   <= 6'd0;
      tmp_minute <= 6'd0;
      tmp_second <= 6'd0;
    end else if (do_commit) begin
      tmp_hour   <= bcd_to_bin(h1, h0);
      tmp_minute <= bcd_to_bin(m1, m0);
`ifdef SECONDS_ENTRY_EN
      tmp_second <= bcd_to_bin(s1, s0);
`else
      tmp_second <= 6'd0;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_time_entry.sv
// Scoreboard bench for bcd_time_entry: expected commits are queued as digits are keyed
// and compared (values and cycle of arrival) whenever load pulses.
module tb_bcd_time_entry;

  logic       clk;
  logic       reset;
  logic       start;
  logic       cancel;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       busy;
  logic [2:0] pos;
  logic       key_err;
  logic       load;
  logic [5:0] tmp_hour;
  logic [5:0] tmp_minute;
  logic [5:0] tmp_second;

  typedef struct {
    int h;
    int m;
    int s;
    int cyc;
  } commit_t;

  commit_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      last_drive_cyc = 0;

  bcd_time_entry dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .busy      (busy),
    .pos       (pos),
    .key_err   (key_err),
    .load      (load),
    .tmp_hour  (tmp_hour),
    .tmp_minute(tmp_minute),
    .tmp_second(tmp_second)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Every load pulse must match the oldest queued commit, on the predicted cycle.
  always @(negedge clk) begin
    if (!reset && load === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_load", 1, 0);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        check_output("tmp_hour", int'(tmp_hour), e.h);
        check_output("tmp_minute", int'(tmp_minute), e.m);
        check_output("tmp_second", int'(tmp_second), e.s);
        check_output("load_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("pos_after_start", int'(pos), 0);
    check_output("busy_after_start", int'(busy), 1);
  endtask

  // Drive one key strobe; exp_pos < 0 skips the position check.
  task automatic apply_stimulus(input int digit, input int exp_err, input int exp_pos);
    key_valid      = 1'b1;
    key_digit      = 4'(digit);
    last_drive_cyc = cyc;
    @(negedge clk);
    key_valid = 1'b0;
    check_output("key_err", int'(key_err), exp_err);
    if (exp_pos >= 0) check_output("pos", int'(pos), exp_pos);
  endtask

  task automatic expect_commit(input int h, input int m, input int s);
    commit_t e;
    e.h   = h;
    e.m   = m;
`ifdef SECONDS_ENTRY_EN
    e.s   = s;
`else
    e.s   = 0 * s;
`endif
    e.cyc = last_drive_cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic seconds_digits(input int d1, input int d0);
`ifdef SECONDS_ENTRY_EN
    apply_stimulus(d1, 0, 5);
    apply_stimulus(d0, 0, -1);
`else
    check_output("seconds_unused", d1 + d0 - d1 - d0, 0 * cyc);
`endif
  endtask

  task automatic enter_time(input int a, input int b, input int c, input int d, input int e, input int f);
    apply_stimulus(a, 0, 1);
    apply_stimulus(b, 0, 2);
    apply_stimulus(c, 0, 3);
`ifdef SECONDS_ENTRY_EN
    apply_stimulus(d, 0, 4);
    seconds_digits(e, f);
`else
    apply_stimulus(d, 0, -1);
    check_output("no_seconds_pos", int'(pos), 7);
`endif
    expect_commit(a * 10 + b, c * 10 + d, e * 10 + f);
    idle(3);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    cancel    = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    idle(2);
    check_output("rst_pos", int'(pos), 7);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_load", int'(load), 0);
    check_output("rst_key_err", int'(key_err), 0);
    check_output("rst_tmp_hour", int'(tmp_hour), 0);
    reset = 1'b0;
    idle(1);

    // Key strobes in IDLE are ignored silently.
    apply_stimulus(3, 0, 7);

    // 17:45:09
    pulse_start();
    enter_time(1, 7, 4, 5, 0, 9);

    // 23:59:59 with H0=4 rejected after H1=2
    pulse_start();
    apply_stimulus(2, 0, 1);
    apply_stimulus(4, 1, 1);
    enter_time_tail:
    begin
      apply_stimulus(3, 0, 2);
      apply_stimulus(5, 0, 3);
`ifdef SECONDS_ENTRY_EN
      apply_stimulus(9, 0, 4);
      seconds_digits(5, 9);
`else
      apply_stimulus(9, 0, -1);
`endif
      expect_commit(23, 59, 59);
      idle(3);
    end

    // 12:00:00 with M1=6 and code 12 rejected
    pulse_start();
    apply_stimulus(1, 0, 1);
    apply_stimulus(2, 0, 2);
    apply_stimulus(6, 1, 2);
    apply_stimulus(12, 1, 2);
    apply_stimulus(0, 0, 3);
`ifdef SECONDS_ENTRY_EN
    apply_stimulus(0, 0, 4);
    seconds_digits(0, 0);
`else
    apply_stimulus(0, 0, -1);
`endif
    expect_commit(12, 0, 0);
    idle(3);

    // 08:30, then cancel a partial entry together with a key strobe
    pulse_start();
    enter_time(0, 8, 3, 0, 0, 0);
    pulse_start();
    apply_stimulus(1, 0, 1);
    apply_stimulus(1, 0, 2);
    cancel    = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd3;
    @(negedge clk);
    cancel    = 1'b0;
    key_valid = 1'b0;
    check_output("cancel_busy", int'(busy), 0);
    check_output("cancel_pos", int'(pos), 7);
    check_output("cancel_key_err", int'(key_err), 0);
    idle(4);
    check_output("hold_tmp_hour", int'(tmp_hour), 8);
    check_output("hold_tmp_minute", int'(tmp_minute), 30);

    // Asynchronous reset between clock edges
    pulse_start();
    apply_stimulus(1, 0, 1);
    #2 reset = 1'b1;
    #1;
    check_output("async_busy", int'(busy), 0);
    check_output("async_pos", int'(pos), 7);
    check_output("async_tmp_hour", int'(tmp_hour), 0);
    check_output("async_tmp_minute", int'(tmp_minute), 0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(2, 0, 7);
    check_output("post_rst_busy", int'(busy), 0);

    // Restart mid-sequence, then 07:15
    pulse_start();
    apply_stimulus(0, 0, 1);
    apply_stimulus(9, 0, 2);
    pulse_start();
    enter_time(0, 7, 1, 5, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check_output("pending_loads", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
